sd_read_arbiter: RTL and testbench
==================================

SD_READ_ARBITER -- requirements
Module: sd_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of read requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, WAIT_DONE watchdog limit in clk cycles.
REQ-003 SHALL have port clk, input, 1, single clock (SD clock domain); all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester read request.
REQ-006 SHALL have port req_addr, input, NUM_REQ*32, packed per-requester block addresses; index i is bits [32*i+31:32*i].
REQ-007 SHALL have port req_ready, output, NUM_REQ, per-requester accept; at most one bit high.
REQ-008 SHALL have port resp_valid, output, NUM_REQ, one-cycle completion pulse to the owning requester.
REQ-009 SHALL have port resp_data, output, 32, read data qualified by resp_valid.
REQ-010 SHALL have port resp_err, output, 1, error flag qualified by resp_valid.
REQ-011 SHALL have port sd_init_done, input, 1, card initialised.
REQ-012 SHALL have ports sd_read_start (output, 1), sd_addr (output, 32), sd_data (input, 32) and sd_read_done (input, 1), forming the card-controller read handshake.
REQ-013 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-014 SHALL implement states WAIT_INIT, IDLE, ISSUE, WAIT_DONE, RESPOND.
REQ-015 WAIT_INIT SHALL go to IDLE on the cycle after sd_init_done=1; req_ready=0 while in WAIT_INIT.
REQ-016 In IDLE, grant SHALL be the first index with req_valid=1, searching upward from rr_ptr with wrap; only req_ready[grant]=1, driven combinationally.
REQ-017 On req_valid[g]&req_ready[g]: latch g and req_addr[g], then go to ISSUE.
REQ-018 ISSUE SHALL assert sd_read_start for exactly one cycle, then go to WAIT_DONE.
REQ-019 sd_addr SHALL equal the latched address from ISSUE through WAIT_DONE; it is 0 otherwise.
REQ-020 WAIT_DONE SHALL, on sd_read_done=1, register sd_data into resp_data, then go to RESPOND.
REQ-021 RESPOND SHALL pulse resp_valid[g] for one cycle, set rr_ptr=(g+1) mod NUM_REQ, and return to IDLE.
REQ-022 Latency: if accepted at cycle T with done at cycle D, sd_read_start SHALL be high at T+1 and resp_valid at D+1; back-to-back accepts are at least 4 cycles apart.
REQ-023 sd_read_done outside WAIT_DONE SHALL be ignored.
REQ-024 If sd_init_done falls in ISSUE or WAIT_DONE: go to RESPOND with resp_err=1 and resp_data=0, then to WAIT_INIT instead of IDLE.
REQ-025 If sd_init_done falls in IDLE: go to WAIT_INIT with no grant.
REQ-026 resp_data SHALL hold its value between captures; a requester dropping req_valid before ready is legal and is not granted.

Reset
REQ-027 Reset SHALL force state=WAIT_INIT, rr_ptr=0, and resp_data, resp_valid, resp_err, req_ready, sd_read_start, sd_addr, busy = 0.
REQ-028 Reset mid-transaction SHALL drop the request silently, with no resp_valid.

Configuration
REQ-029 With SD_ARB_TIMEOUT_EN defined, a counter SHALL clear on entering WAIT_DONE; on reaching TIMEOUT_CYCLES without sd_read_done, go to RESPOND with resp_err=1 and resp_data=0, then IDLE.
REQ-030 Without SD_ARB_TIMEOUT_EN, WAIT_DONE SHALL wait indefinitely, no counter logic SHALL exist, and TIMEOUT_CYCLES SHALL be unused.

Structure
REQ-031 Package sd_pkg SHALL hold the arbiter state enum typedef and constants SD_ADDR_W=32 and SD_DATA_W=32.
REQ-032 Round-robin grant selection SHALL be sub-module sd_rr_arbiter (combinational; inputs req and ptr, output one-hot grant).

Verification
REQ-033 The bench SHALL cover the scenarios below.
- sd_init_done=0 for 10 cycles with req_valid=2'b11 -> req_ready=0 throughout; grant req0 on the cycle after init_done.
- Single req1 with addr=0x00000200 and read_done at +20 cycles with data 0xDEADBEEF -> sd_read_start at T+1, sd_addr=0x200, resp_valid=2'b10, resp_data=0xDEADBEEF, resp_err=0.
- req_valid=2'b11 held for 4 transactions -> grant order 0,1,0,1.
- sd_init_done dropped during WAIT_DONE -> resp_valid pulse with resp_err=1 and resp_data=0, then WAIT_INIT.
- With SD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no read_done -> resp_err=1 sixteen cycles after entering WAIT_DONE, then IDLE.
- Reset asserted in WAIT_DONE -> all outputs 0 next cycle, no resp_valid; a stray read_done is ignored.

Source files
------------

// File: rtl/sd_pkg.sv
// sd_pkg: shared types and widths for the SD read arbiter.
//   sd_state_e - arbiter FSM states
//   SD_ADDR_W  - card block address width
//   SD_DATA_W  - card read data width
package sd_pkg;
  localparam int SD_ADDR_W = 32;
  localparam int SD_DATA_W = 32;
  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    ISSUE,
    WAIT_DONE,
    RESPOND
  } sd_state_e;
endpackage

// File: rtl/sd_rr_arbiter.sv
// sd_rr_arbiter: combinational round-robin grant, first requester at or above ptr with wrap.
//   req   - request vector
//   ptr   - highest-priority index (must be < NUM_REQ)
//   grant - one-hot grant, all zero when no request
module sd_rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant
);
  logic [PW:0]   s;
  logic [PW-1:0] idx;
  logic          found;
  always_comb begin
    grant = '0;
    found = 1'b0;
    s     = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s   = {1'b0, ptr} + (PW+1)'(k);
      s   = (s >= (PW+1)'(NUM_REQ)) ? s - (PW+1)'(NUM_REQ) : s;
      idx = s[PW-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sd_read_arbiter.sv
// sd_read_arbiter: round-robin arbiter sharing one SD card read port among NUM_REQ requesters.
//   clk, reset                - clock, synchronous active-high reset
//   req_valid/req_addr/req_ready - per-requester request handshake (req_ready one-hot, combinational)
//   resp_valid/resp_data/resp_err - one-cycle completion pulse to the owner, data and error flag
//   sd_init_done              - card initialised; loss aborts the transaction in flight
//   sd_read_start/sd_addr/sd_data/sd_read_done - card controller read handshake
//   busy                      - high whenever the arbiter is not IDLE (reads 0 on the cycle after reset)
// Optional macro SD_ARB_TIMEOUT_EN: adds a WAIT_DONE watchdog of TIMEOUT_CYCLES cycles.
module sd_read_arbiter
  import sd_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*SD_ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [SD_DATA_W-1:0]         resp_data,
  output logic                         resp_err,
  input  logic                         sd_init_done,
  output logic                         sd_read_start,
  output logic [SD_ADDR_W-1:0]         sd_addr,
  input  logic [SD_DATA_W-1:0]         sd_data,
  input  logic                         sd_read_done,
  output logic                         busy
);
  localparam int PW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("sd_read_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("sd_read_arbiter: TIMEOUT_CYCLES must be positive");
  end

  sd_state_e            state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d, gidx_q, gidx_d, gidx;
  logic [SD_ADDR_W-1:0] addr_q, addr_d, sel_addr;
  logic [SD_DATA_W-1:0] data_q, data_d;
  logic                 err_q, err_d, lost_q, lost_d, busy_q;
  logic [NUM_REQ-1:0]   grant;
  logic                 accept, expired;

  sd_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req  (req_valid),
    .ptr  (ptr_q),
    .grant(grant)
  );

`ifdef SD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  // Held at zero outside WAIT_DONE, so it reads 0 on the first WAIT_DONE cycle.
  always_ff @(posedge clk)
    cnt_q <= (reset || state_q != WAIT_DONE) ? '0 : cnt_q + 1'b1;
  assign expired = cnt_q == CW'(TIMEOUT_CYCLES - 1);
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    gidx     = '0;
    sel_addr = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (grant[k]) begin
        gidx     = PW'(k);
        sel_addr = req_addr[k*SD_ADDR_W +: SD_ADDR_W];
      end
  end

  assign accept = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_INIT;
      ptr_q   <= '0;
      gidx_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      lost_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      lost_q  <= lost_d;
      busy_q  <= state_d != IDLE;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    lost_d  = lost_q;
    case (state_q)
      WAIT_INIT: state_d = sd_init_done ? IDLE : WAIT_INIT;
      IDLE:
        if (!sd_init_done) state_d = WAIT_INIT;
        else if (accept) begin
          state_d = ISSUE;
          gidx_d  = gidx;
          addr_d  = sel_addr;
          err_d   = 1'b0;
          lost_d  = 1'b0;
        end
      ISSUE, WAIT_DONE:
        // Card loss aborts with an error response and forces re-initialisation.
        if (!sd_init_done) begin
          state_d = RESPOND;
          data_d  = '0;
          err_d   = 1'b1;
          lost_d  = 1'b1;
        end else if (state_q == ISSUE) state_d = WAIT_DONE;
        else if (sd_read_done) begin
          state_d = RESPOND;
          data_d  = sd_data;
        end else if (expired) begin
          state_d = RESPOND;
          data_d  = '0;
          err_d   = 1'b1;
        end
      RESPOND: begin
        ptr_d   = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + PW'(1);
        state_d = lost_q ? WAIT_INIT : IDLE;
      end
      default: state_d = WAIT_INIT;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == IDLE && sd_init_done && !reset) ? grant : '0;
    resp_valid    = (state_q == RESPOND) ? NUM_REQ'(1) << gidx_q : '0;
    resp_err      = state_q == RESPOND && err_q;
    resp_data     = data_q;
    sd_read_start = state_q == ISSUE;
    sd_addr       = (state_q == ISSUE || state_q == WAIT_DONE) ? addr_q : '0;
    busy          = busy_q;
  end
endmodule

// File: tb/tb_sd_read_arbiter.sv
// tb_sd_read_arbiter: directed stimulus, timestamp-based reference model and literal spot checks.
module tb_sd_read_arbiter;
  localparam int N  = 2;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset, sd_init_done, sd_read_start, sd_read_done, resp_err, busy;
  logic [N-1:0]   req_valid, req_ready, resp_valid;
  logic [N*32-1:0] req_addr;
  logic [31:0]    resp_data, sd_addr, sd_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sd_read_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .sd_init_done (sd_init_done),
    .sd_read_start(sd_read_start),
    .sd_addr      (sd_addr),
    .sd_data      (sd_data),
    .sd_read_done (sd_read_done),
    .busy         (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_idx(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Reference model: mode 0 = waiting for card, 1 = idle, 2 = transaction owned.
  // A transaction accepted at cycle t_acc starts at t_acc+1, may finish from
  // t_acc+2 on, and responds at t_resp (one cycle after its completion event).
  int          cyc = 0;
  bit          armed = 0, mask = 0;
  int          mode = 0, t_acc = 0, t_resp = -1, own = 0, ptr = 0, cmp_g;
  logic [31:0] m_addr = '0, m_data = '0;
  bit          m_err = 0, m_fatal = 0;

  always @(posedge clk) begin
    if (reset) begin
      mode = 0; ptr = 0; m_data = '0; t_resp = -1; mask = 1; armed = 1;
    end else begin
      mask = 0;
      case (mode)
        0: if (sd_init_done) mode = 1;
        1:
          if (!sd_init_done) mode = 0;
          else if (rr_idx(ptr, req_valid) >= 0) begin
            own = rr_idx(ptr, req_valid);
            mode = 2; t_acc = cyc; t_resp = -1; m_err = 0; m_fatal = 0;
            m_addr = req_addr[own*32 +: 32];
          end
        default:
          if (cyc == t_resp) begin
            ptr = (own + 1) % N;
            mode = m_fatal ? 0 : 1;
          end else if (t_resp < 0 && cyc >= t_acc + 1) begin
            if (!sd_init_done) begin
              t_resp = cyc + 1; m_err = 1; m_fatal = 1; m_data = '0;
            end else if (cyc >= t_acc + 2 && sd_read_done) begin
              t_resp = cyc + 1; m_data = sd_data;
            end
`ifdef SD_ARB_TIMEOUT_EN
            else if (cyc == t_acc + 2 + TO - 1) begin
              t_resp = cyc + 1; m_err = 1; m_data = '0;
            end
`endif
          end
      endcase
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (armed) begin
      cmp_g = (mode == 1 && sd_init_done && !reset) ? rr_idx(ptr, req_valid) : -1;
      chk("m_req_ready", req_ready, cmp_g >= 0 ? N'(1) << cmp_g : '0);
      chk("m_start", sd_read_start, mode == 2 && cyc == t_acc + 1);
      chk("m_sd_addr", sd_addr,
          (mode == 2 && cyc >= t_acc + 1 && (t_resp < 0 || cyc < t_resp)) ? m_addr : '0);
      chk("m_resp_valid", resp_valid, (mode == 2 && cyc == t_resp) ? N'(1) << own : '0);
      chk("m_resp_err", resp_err, mode == 2 && cyc == t_resp && m_err);
      chk("m_resp_data", resp_data, m_data);
      chk("m_busy", busy, !mask && mode != 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1; sd_init_done = 0; req_valid = '0; req_addr = '0; sd_read_done = 0; sd_data = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_start", sd_read_start, 0);
    chk("rst_addr", sd_addr, 0);
    chk("rst_rv", resp_valid, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_err", resp_err, 0);
    reset = 0; req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("wait_init_ready", req_ready, 0);
    end
    sd_init_done = 1;
    tick();
    chk("grant_after_init", req_ready, 2'b01);
    tick();
    req_valid = '0;
    chk("first_start", sd_read_start, 1);
    tick();
    sd_read_done = 1; sd_data = 32'h1111_1111;
    tick();
    sd_read_done = 0;
    chk("first_rv", resp_valid, 2'b01);
    chk("first_data", resp_data, 32'h1111_1111);
    tick();
    req_valid = 2'b10; req_addr = {32'h0000_0200, 32'h0};
    #1;
    chk("req1_ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    chk("req1_start", sd_read_start, 1);
    chk("req1_addr", sd_addr, 32'h200);
    repeat (18) tick();
    chk("req1_addr_hold", sd_addr, 32'h200);
    tick();
    sd_read_done = 1; sd_data = 32'hDEAD_BEEF;
    tick();
    sd_read_done = 0;
    chk("req1_rv", resp_valid, 2'b10);
    chk("req1_data", resp_data, 32'hDEAD_BEEF);
    chk("req1_err", resp_err, 0);
    tick();
    req_valid = 2'b11; req_addr = {32'h0000_0400, 32'h0000_0300};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant", req_ready, (i % 2) ? 2'b10 : 2'b01);
      tick(); tick();
      sd_read_done = 1; sd_data = 32'hA0 + i;
      tick();
      sd_read_done = 0;
      chk("rr_data", resp_data, 32'hA0 + i);
      tick();
    end
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    sd_init_done = 0;
    tick();
    chk("drop_rv", resp_valid, 2'b01);
    chk("drop_err", resp_err, 1);
    chk("drop_data", resp_data, 0);
    tick();
    chk("drop_busy", busy, 1);
    req_valid = 2'b11;
    #1;
    chk("drop_ready", req_ready, 0);
    sd_init_done = 1;
    tick();
    chk("reinit_grant", req_ready, 2'b10);
    req_valid = '0;
`ifdef SD_ARB_TIMEOUT_EN
    tick();
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    tick();
    repeat (15) tick();
    chk("to_early_rv", resp_valid, 0);
    tick();
    chk("to_err", resp_err, 1);
    chk("to_rv", resp_valid, 2'b01);
    chk("to_data", resp_data, 0);
    tick();
    chk("to_busy", busy, 0);
`endif
    tick();
    req_valid = 2'b11;
    tick();
    req_valid = '0;
    tick();
    reset = 1;
    tick();
    chk("rst2_busy", busy, 0);
    chk("rst2_addr", sd_addr, 0);
    chk("rst2_start", sd_read_start, 0);
    chk("rst2_rv", resp_valid, 0);
    chk("rst2_ready", req_ready, 0);
    chk("rst2_err", resp_err, 0);
    reset = 0; sd_read_done = 1; sd_data = 32'h0BAD_0BAD;
    tick();
    sd_read_done = 0;
    chk("stray_rv", resp_valid, 0);
    chk("stray_data", resp_data, 0);
    tick();
    chk("stray_data_hold", resp_data, 0);
    req_valid = 2'b01;
    #1;
    chk("post_reset_grant", req_ready, 2'b01);
    req_valid = '0;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
